count_wrap_monitor: RTL and testbench

Downstream observer for the free-running 4-bit counter. Samples the counter value every clock and detects two events: wrap-around (15→0) and discontinuities (any step other than +1 mod 16, e.g. an upstream reset). Each event is logged with a running wrap total into a small FIFO that is drained over a valid/ready handshake. It sits directly on the counter's `count` output and feeds the debug/status logic.

---
 rtl/count_mon_pkg.sv | 30 +++
 rtl/count_mon_fifo.sv | 63 ++++++
 rtl/count_wrap_monitor.sv | 143 ++++++++++++++
 tb/tb_count_wrap_monitor.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_mon_pkg.sv
// count_mon_pkg: types and constants shared by the 4-bit counter wrap monitor.
// The event record is {ev_type, wraps}. ev_rec_t is the record at the default
// 8-bit wrap-total width, for downstream status logic that uses the default.
package count_mon_pkg;

  localparam int COUNT_W        = 4;
  localparam int WRAP_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    EV_NONE = 2'b00,
    EV_WRAP = 2'b01,
    EV_JUMP = 2'b10
  } ev_type_t;

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } mon_state_t;

  typedef struct packed {
    ev_type_t                  ev_type;
    logic [WRAP_W_DEFAULT-1:0] wraps;
  } ev_rec_t;

  // Expected successor of a counter value; wraps 15 -> 0 naturally.
  function automatic logic [COUNT_W-1:0] count_succ(input logic [COUNT_W-1:0] c);
    return c + 1'b1;
  endfunction

endpackage

// File: rtl/count_mon_fifo.sv
// count_mon_fifo: synchronous FIFO for monitor event records.
// DEPTH must be a power of two (>= 2) so the pointers wrap by overflow.
// A push into a full FIFO succeeds only if a pop happens in the same cycle;
// otherwise the entry is dropped and 'drop' pulses for that cycle.
// The head is read from storage and forced to zero while empty, so nothing
// stale from before a reset is ever presented.
module count_mon_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_FILL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   fill;
  logic             do_push;
  logic             do_pop;

  assign empty   = (fill == '0);
  assign full    = (fill == FULL_FILL);
  // A pop is meaningless on an empty FIFO; a pop frees the slot a full push needs.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  assign dout = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/count_wrap_monitor.sv
// count_wrap_monitor: watches a free-running 4-bit counter and logs WRAP
// (15 -> 0) and JUMP (any step other than +1 mod 16) events, each tagged with
// the running wrap total, into a FIFO drained over valid/ready.
// Optional feature macro: COUNT_MON_JUMP_EN (JUMP detection; off by default,
// in which case only WRAP events are logged).
//
// Handshake: ev_valid is high while the FIFO head holds an event; the head is
// consumed on any rising clk edge where ev_valid && ev_ready. The head
// (ev_type, ev_wraps) holds steady while ev_valid && !ev_ready, and ev_valid
// never depends combinationally on ev_ready.
//
// dbg_state exposes the monitor FSM (0 = IDLE, 1 = TRACK).
module count_wrap_monitor
  import count_mon_pkg::*;
#(
  parameter int WRAP_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [3:0]        count,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [1:0]        ev_type,
  output logic [WRAP_W-1:0] ev_wraps,
  output logic [WRAP_W-1:0] wrap_total,
  output logic              overflow,
  output logic              dbg_state
);

  localparam int REC_W = 2 + WRAP_W;

  mon_state_t         state;
  mon_state_t         next_state;
  logic [COUNT_W-1:0] prev;
  logic               sample;
  logic               is_wrap;
  logic               is_jump;
  logic               push;
  ev_type_t           rec_type;
  logic [WRAP_W-1:0]  rec_wraps;
  logic [WRAP_W-1:0]  wrap_inc;
  logic [REC_W-1:0]   rec;
  logic [REC_W-1:0]   head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_drop;

  assign wrap_inc = wrap_total + 1'b1;

  // Next-state and event detection. IDLE only primes prev, so the first sample
  // after reset or re-enable can never be reported as a discontinuity.
  always_comb begin
    next_state = state;
    sample     = 1'b0;
    is_wrap    = 1'b0;
    is_jump    = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          next_state = TRACK;
          sample     = 1'b1;
        end
      end
      TRACK: begin
        if (!enable) begin
          next_state = IDLE;
        end else begin
          sample  = 1'b1;
          is_wrap = (prev == 4'hF) && (count == 4'h0);
`ifdef COUNT_MON_JUMP_EN
          // 15 -> 0 is a legal +1 step, so WRAP and JUMP never coincide.
          is_jump = (count != count_succ(prev));
`endif
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // A WRAP record carries the already-incremented total; a JUMP carries the current one.
  always_comb begin
    rec_type  = EV_JUMP;
    rec_wraps = wrap_total;
    if (is_wrap) begin
      rec_type  = EV_WRAP;
      rec_wraps = wrap_inc;
    end
  end

  assign push = is_wrap || is_jump;
  assign rec  = {rec_type, rec_wraps};

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Previous sample; held while disabled.
  always_ff @(posedge clk) begin
    if (reset)       prev <= '0;
    else if (sample) prev <= count;
  end

  // Live wrap total; counts even when the event itself is dropped.
  always_ff @(posedge clk) begin
    if (reset)        wrap_total <= '0;
    else if (is_wrap) wrap_total <= wrap_inc;
  end

  // Sticky overflow: set whenever an event is lost to a full FIFO.
  always_ff @(posedge clk) begin
    if (reset)          overflow <= 1'b0;
    else if (fifo_drop) overflow <= 1'b1;
  end

  count_mon_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (rec),
    .pop   (ev_ready),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  assign ev_valid  = !fifo_empty;
  assign ev_type   = head[REC_W-1:WRAP_W];
  assign ev_wraps  = head[WRAP_W-1:0];
  assign dbg_state = state;

  // Full is implied by the drop pulse; kept visible for timing reports and probes.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_count_wrap_monitor.sv
// Testbench for count_wrap_monitor: directed scenarios plus a randomized run,
// all checked against a behavioural event model (expected-event queue).
module tb_count_wrap_monitor;

  localparam int WRAP_W = 8;
  localparam int DEPTH  = 4;
`ifdef COUNT_MON_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              enable;
  logic [3:0]        count;
  logic              ev_valid;
  logic              ev_ready;
  logic [1:0]        ev_type;
  logic [WRAP_W-1:0] ev_wraps;
  logic [WRAP_W-1:0] wrap_total;
  logic              overflow;
  logic              dbg_state;

  count_wrap_monitor #(
    .WRAP_W     (WRAP_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .count      (count),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_type    (ev_type),
    .ev_wraps   (ev_wraps),
    .wrap_total (wrap_total),
    .overflow   (overflow),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  logic [WRAP_W+1:0] exp_q[$];
  logic [WRAP_W-1:0] m_total;
  bit                m_ovf;
  bit                m_have_prev;
  int                m_prev;
  int                n_vec;
  int                n_err;

  // Applies one clock of stimulus, then advances the model by the same edge.
  task automatic step(input logic en, input logic [3:0] c, input logic rdy);
    logic [WRAP_W+1:0] rec;
    bit                have_ev;
    enable   = en;
    count    = c;
    ev_ready = rdy;
    @(posedge clk);
    if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
    if (en) begin
      if (m_have_prev) begin
        have_ev = 1'b0;
        rec     = '0;
        if (m_prev == 15 && c == 4'd0) begin
          m_total = m_total + 8'd1;
          rec     = {2'b01, m_total};
          have_ev = 1'b1;
        end else if (JUMP_EN && int'(c) != (m_prev + 1) % 16) begin
          rec     = {2'b10, m_total};
          have_ev = 1'b1;
        end
        if (have_ev) begin
          if (exp_q.size() < DEPTH) exp_q.push_back(rec);
          else m_ovf = 1'b1;
        end
      end
      m_prev      = int'(c);
      m_have_prev = 1'b1;
    end else begin
      m_have_prev = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    exp_q.delete();
    m_total     = '0;
    m_ovf       = 1'b0;
    m_have_prev = 1'b0;
    m_prev      = 0;
    #1;
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_vec++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL reset_ev_valid: got %0h want 0", ev_valid); end
    n_vec++; if (ev_type !== 2'b00) begin n_err++; $display("FAIL reset_ev_type: got %0h want 0", ev_type); end
    n_vec++; if (ev_wraps !== 8'd0) begin n_err++; $display("FAIL reset_ev_wraps: got %0h want 0", ev_wraps); end
    n_vec++; if (wrap_total !== 8'd0) begin n_err++; $display("FAIL reset_wrap_total: got %0h want 0", wrap_total); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %0h want 0", overflow); end
    n_vec++; if (dbg_state !== 1'b0) begin n_err++; $display("FAIL reset_state: got %0h want 0", dbg_state); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 4'(i), 1'b0);
      n_vec++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL wrap_pre_%0d: got ev_valid %0h want 0", i, ev_valid); end
    end
    step(1'b1, 4'd0, 1'b0);
    n_vec++; if ({ev_valid, ev_type, ev_wraps} !== {1'b1, 2'b01, 8'd1}) begin
      n_err++; $display("FAIL wrap_event: got v=%0h t=%0h w=%0h want v=1 t=1 w=1", ev_valid, ev_type, ev_wraps);
    end
    n_vec++; if (wrap_total !== 8'd1) begin n_err++; $display("FAIL wrap_total: got %0h want 1", wrap_total); end
    step(1'b1, 4'd1, 1'b1);
    n_vec++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL wrap_single: got ev_valid %0h want 0", ev_valid); end
  endtask

  task automatic test_jump();
    logic [10:0] exp_head;
    exp_head = JUMP_EN ? {1'b1, 2'b10, 8'd1} : 11'd0;
    step(1'b1, 4'd2, 1'b0);
    step(1'b1, 4'd3, 1'b0);
    step(1'b1, 4'd4, 1'b0);
    n_vec++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL jump_normal_step: got ev_valid %0h want 0", ev_valid); end
    step(1'b1, 4'd9, 1'b0);
    n_vec++; if ({ev_valid, ev_type, ev_wraps} !== exp_head) begin
      n_err++; $display("FAIL jump_event: got %0h want %0h", {ev_valid, ev_type, ev_wraps}, exp_head);
    end
    step(1'b1, 4'd10, 1'b0);
    n_vec++; if ({ev_valid, ev_type, ev_wraps} !== exp_head) begin
      n_err++; $display("FAIL jump_hold: got %0h want %0h", {ev_valid, ev_type, ev_wraps}, exp_head);
    end
    step(1'b1, 4'd11, 1'b1);
    n_vec++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL jump_drain: got ev_valid %0h want 0", ev_valid); end
    n_vec++; if (wrap_total !== 8'd1) begin n_err++; $display("FAIL jump_total: got %0h want 1", wrap_total); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i <= 80; i++) step(1'b1, 4'(i % 16), 1'b0);
    n_vec++; if (wrap_total !== 8'd5) begin n_err++; $display("FAIL ovf_total: got %0h want 5", wrap_total); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %0h want 1", overflow); end
    for (int k = 1; k <= 4; k++) begin
      n_vec++; if ({ev_valid, ev_type, ev_wraps} !== {1'b1, 2'b01, 8'(k)}) begin
        n_err++; $display("FAIL ovf_entry_%0d: got v=%0h t=%0h w=%0h want v=1 t=1 w=%0h", k, ev_valid, ev_type, ev_wraps, k);
      end
      step(1'b1, 4'(k), 1'b1);
    end
    n_vec++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty: got ev_valid %0h want 0", ev_valid); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %0h want 1", overflow); end
  endtask

  task automatic test_full_coincide();
    do_reset();
    for (int i = 0; i < 80; i++) step(1'b1, 4'(i % 16), 1'b0);
    n_vec++; if ({ev_valid, ev_wraps} !== {1'b1, 8'd1}) begin
      n_err++; $display("FAIL full_head: got v=%0h w=%0h want v=1 w=1", ev_valid, ev_wraps);
    end
    step(1'b1, 4'd0, 1'b1);
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL full_no_ovf: got %0h want 0", overflow); end
    n_vec++; if (wrap_total !== 8'd5) begin n_err++; $display("FAIL full_total: got %0h want 5", wrap_total); end
    for (int k = 2; k <= 5; k++) begin
      n_vec++; if ({ev_valid, ev_type, ev_wraps} !== {1'b1, 2'b01, 8'(k)}) begin
        n_err++; $display("FAIL full_order_%0d: got v=%0h t=%0h w=%0h want v=1 t=1 w=%0h", k, ev_valid, ev_type, ev_wraps, k);
      end
      step(1'b1, 4'(k - 1), 1'b1);
    end
    n_vec++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL full_empty: got ev_valid %0h want 0", ev_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i <= 40; i++) step(1'b1, 4'(i % 16), 1'b0);
    n_vec++; if (exp_q.size() != 2 || ev_valid !== 1'b1) begin
      n_err++; $display("FAIL mid_queued: got ev_valid %0h want 1 (model depth %0d)", ev_valid, exp_q.size());
    end
    count = 4'd9;
    do_reset();
    n_vec++; if ({ev_valid, ev_type, ev_wraps, wrap_total, overflow} !== 20'd0) begin
      n_err++; $display("FAIL mid_reset_zero: got v=%0h t=%0h w=%0h tot=%0h o=%0h want all 0", ev_valid, ev_type, ev_wraps, wrap_total, overflow);
    end
    step(1'b1, 4'd7, 1'b0);
    step(1'b1, 4'd8, 1'b0);
    n_vec++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL mid_no_jump: got ev_valid %0h want 0", ev_valid); end
    n_vec++; if (dbg_state !== 1'b1) begin n_err++; $display("FAIL mid_state: got %0h want 1", dbg_state); end
  endtask

  task automatic test_enable_toggle();
    logic [3:0] gap [3];
    gap[0] = 4'd13; gap[1] = 4'd15; gap[2] = 4'd0;
    step(1'b1, 4'd9, 1'b0);
    step(1'b1, 4'd10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, gap[i], 1'b0);
      n_vec++; if ({ev_valid, dbg_state} !== 2'b00) begin
        n_err++; $display("FAIL en_low_%0d: got v=%0h st=%0h want 0 0", i, ev_valid, dbg_state);
      end
    end
    step(1'b1, 4'd5, 1'b0);
    n_vec++; if ({ev_valid, dbg_state} !== 2'b01) begin
      n_err++; $display("FAIL en_reprime: got v=%0h st=%0h want v=0 st=1", ev_valid, dbg_state);
    end
    step(1'b1, 4'd6, 1'b0);
    n_vec++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL en_after: got ev_valid %0h want 0", ev_valid); end
    n_vec++; if (wrap_total !== 8'd0) begin n_err++; $display("FAIL en_total: got %0h want 0", wrap_total); end
  endtask

  task automatic test_random();
    logic [3:0]        c_run;
    logic [WRAP_W+1:0] exp_head;
    logic              en;
    logic              rdy;
    do_reset();
    c_run = 4'($urandom_range(0, 15));
    for (int n = 0; n < 700; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      en  = ($urandom_range(0, 9) != 0);
      rdy = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) < 8) c_run = c_run + 4'd1;
      else c_run = 4'($urandom_range(0, 15));
      step(en, c_run, rdy);
      exp_head = (exp_q.size() > 0) ? exp_q[0] : '0;
      n_vec++; if (ev_valid !== (exp_q.size() > 0)) begin
        n_err++; $display("FAIL rnd_valid_%0d: got %0h want %0h", n, ev_valid, exp_q.size() > 0);
      end
      n_vec++; if ({ev_type, ev_wraps} !== exp_head) begin
        n_err++; $display("FAIL rnd_head_%0d: got %0h want %0h", n, {ev_type, ev_wraps}, exp_head);
      end
      n_vec++; if (wrap_total !== m_total) begin
        n_err++; $display("FAIL rnd_total_%0d: got %0h want %0h", n, wrap_total, m_total);
      end
      n_vec++; if (overflow !== m_ovf) begin
        n_err++; $display("FAIL rnd_ovf_%0d: got %0h want %0h", n, overflow, m_ovf);
      end
      n_vec++; if (dbg_state !== m_have_prev) begin
        n_err++; $display("FAIL rnd_state_%0d: got %0h want %0h", n, dbg_state, m_have_prev);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_vec       = 0;
    n_err       = 0;
    reset       = 1'b1;
    enable      = 1'b0;
    count       = 4'd0;
    ev_ready    = 1'b0;
    m_total     = '0;
    m_ovf       = 1'b0;
    m_have_prev = 1'b0;
    m_prev      = 0;
    test_reset();
    test_wrap();
    test_jump();
    test_overflow();
    test_full_coincide();
    test_reset_mid();
    test_enable_toggle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
